router_rd_ctrl: RTL and testbench

ROUTER_RD_CTRL -- requirements
Module: router_rd_ctrl

---
 rtl/router_rd_ctrl.sv | 157 +++++++++++++++
 tb/tb_router_rd_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_rd_ctrl.sv
// router_rd_ctrl: output-port read controller for the router.
// Pops the port FIFO into a registered output stage and parses
// header/payload/parity framing. It checks parity and times out stalls.
// Optional feature macro: ROUTER_RD_PARITY_CHK_EN enables the running
//   XOR and parity_err. When it is undefined, parity_err is tied to 0.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high reset
//   fifo_empty  port FIFO holds no bytes
//   fifo_dout   FIFO head byte (show-ahead)
//   read_enb    destination accepts data_out this cycle
//   fifo_rd_en  combinational pop of the FIFO head
//   data_out    registered byte to the destination
//   vld_out     data_out is valid
//   soft_reset  one-cycle pulse on stall timeout
//   pkt_done    pulse when the parity byte is consumed
//   parity_err  pulse with pkt_done on parity mismatch
//   busy        packet in progress
module router_rd_ctrl #(
  parameter int TIMEOUT_CYCLES = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  input  logic       read_enb,
  output logic       fifo_rd_en,
  output logic [7:0] data_out,
  output logic       vld_out,
  output logic       soft_reset,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [1:0] HDR = 2'd0;
  localparam logic [1:0] PLD = 2'd1;
  localparam logic [1:0] PAR = 2'd2;

  // timeout fires on the stall cycle that brings the count to the limit
  localparam logic [5:0] STALL_LIM =
    6'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [5:0] rem;
  logic [5:0] rem_nx;
  logic [5:0] stall_cnt;
  logic       last_q;

  logic st_hdr;
  logic st_pld;
  logic st_par;
  logic stall;
  logic timeout;
  logic load;
  logic consume;

  assign st_hdr = (state == HDR);
  assign st_pld = (state == PLD);
  assign st_par = (state == PAR);

  assign stall   = vld_out & ~read_enb;
  assign timeout = stall & (stall_cnt == STALL_LIM)
                 & ~reset;

  assign load = ~fifo_empty
              & (~vld_out | read_enb)
              & ~timeout
              & ~reset;

  // a timeout cycle is always a stall cycle, so it never consumes
  assign consume = vld_out & read_enb & ~reset;

  assign fifo_rd_en = load;
  assign soft_reset = timeout;
  assign pkt_done   = consume & last_q;
  assign busy       = ~st_hdr | vld_out;

  // state tracks the role of the next byte to be loaded
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    if (load) begin
      unique case (1'b1)
        st_hdr: begin
          rem_nx   = fifo_dout[7:2];
          state_nx = (fifo_dout[7:2] == 6'd0)
                   ? PAR : PLD;
        end
        st_pld: begin
          rem_nx = rem - 6'd1;
          if (rem == 6'd1)
            state_nx = PAR;
        end
        st_par: begin
          state_nx = HDR;
        end
        default: begin
          state_nx = HDR;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= HDR;
      rem       <= 6'd0;
      stall_cnt <= 6'd0;
      vld_out   <= 1'b0;
      data_out  <= 8'h00;
      last_q    <= 1'b0;
    end else if (timeout) begin
      state     <= HDR;
      rem       <= 6'd0;
      stall_cnt <= 6'd0;
      vld_out   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      rem       <= rem_nx;
      stall_cnt <= stall ? stall_cnt + 6'd1
                         : 6'd0;
      if (load) begin
        data_out <= fifo_dout;
        vld_out  <= 1'b1;
        last_q   <= st_par;
      end else if (consume) begin
        vld_out <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

`ifdef ROUTER_RD_PARITY_CHK_EN
  logic [7:0] xor_q;

  // header load restarts the sum; parity byte is not folded in
  always_ff @(posedge clock) begin
    if (reset || timeout) begin
      xor_q <= 8'h00;
    end else if (load && st_hdr) begin
      xor_q <= fifo_dout;
    end else if (load && st_pld) begin
      xor_q <= xor_q ^ fifo_dout;
    end
  end

  // the last-byte register holds the parity byte here
  assign parity_err = pkt_done
                    & (xor_q != data_out);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_rd_ctrl.sv
// tb_router_rd_ctrl: directed vector bench for router_rd_ctrl.
// Inputs are driven directly each cycle, with no FIFO model.
module tb_router_rd_ctrl;

`ifdef ROUTER_RD_PARITY_CHK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       read_enb;
  logic       fifo_rd_en;
  logic [7:0] data_out;
  logic       vld_out;
  logic       soft_reset;
  logic       pkt_done;
  logic       parity_err;
  logic       busy;

  int total;
  int bad;

  router_rd_ctrl #(.TIMEOUT_CYCLES(30)) dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .read_enb   (read_enb),
    .fifo_rd_en (fifo_rd_en),
    .data_out   (data_out),
    .vld_out    (vld_out),
    .soft_reset (soft_reset),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit         rst;
    bit         emp;
    logic [7:0] din;
    bit         ren;
    bit         e_rd;
    bit         e_vld;
    logic [7:0] e_dout;
    bit         e_done;
    bit         e_perr;
    bit         e_busy;
  } vec_t;

  vec_t tv [26];

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  // apply inputs away from the rising edge, settle, then sample
  task automatic step(input bit rst, input bit emp,
                      input logic [7:0] din,
                      input bit ren);
    @(negedge clock);
    reset      = rst;
    fifo_empty = emp;
    fifo_dout  = din;
    read_enb   = ren;
    #2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset      = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout  = 8'h00;
    read_enb   = 1'b0;

    // streaming packet 0D 11 22 33 parity 0D
    tv[0]  = '{1'b1,1'b0,8'hAA,1'b1, 1'b0,1'b0,8'h00,1'b0,1'b0,1'b0};
    tv[1]  = '{1'b0,1'b1,8'h00,1'b1, 1'b0,1'b0,8'h00,1'b0,1'b0,1'b0};
    tv[2]  = '{1'b0,1'b0,8'h0D,1'b1, 1'b1,1'b0,8'h00,1'b0,1'b0,1'b0};
    tv[3]  = '{1'b0,1'b0,8'h11,1'b1, 1'b1,1'b1,8'h0D,1'b0,1'b0,1'b1};
    tv[4]  = '{1'b0,1'b0,8'h22,1'b1, 1'b1,1'b1,8'h11,1'b0,1'b0,1'b1};
    tv[5]  = '{1'b0,1'b0,8'h33,1'b1, 1'b1,1'b1,8'h22,1'b0,1'b0,1'b1};
    tv[6]  = '{1'b0,1'b0,8'h0D,1'b1, 1'b1,1'b1,8'h33,1'b0,1'b0,1'b1};
    tv[7]  = '{1'b0,1'b1,8'h00,1'b1, 1'b0,1'b1,8'h0D,1'b1,1'b0,1'b1};
    tv[8]  = '{1'b0,1'b1,8'h00,1'b1, 1'b0,1'b0,8'h0D,1'b0,1'b0,1'b0};
    // same packet with a bad parity byte FF, then a back-to-back
    // zero-length packet whose header loads on the parity consume
    tv[9]  = '{1'b0,1'b0,8'h0D,1'b1, 1'b1,1'b0,8'h0D,1'b0,1'b0,1'b0};
    tv[10] = '{1'b0,1'b0,8'h11,1'b1, 1'b1,1'b1,8'h0D,1'b0,1'b0,1'b1};
    tv[11] = '{1'b0,1'b0,8'h22,1'b1, 1'b1,1'b1,8'h11,1'b0,1'b0,1'b1};
    tv[12] = '{1'b0,1'b0,8'h33,1'b1, 1'b1,1'b1,8'h22,1'b0,1'b0,1'b1};
    tv[13] = '{1'b0,1'b0,8'hFF,1'b1, 1'b1,1'b1,8'h33,1'b0,1'b0,1'b1};
    tv[14] = '{1'b0,1'b0,8'h02,1'b1, 1'b1,1'b1,8'hFF,1'b1,PCHK,1'b1};
    tv[15] = '{1'b0,1'b0,8'h02,1'b1, 1'b1,1'b1,8'h02,1'b0,1'b0,1'b1};
    tv[16] = '{1'b0,1'b1,8'h00,1'b1, 0,1'b1,8'h02,1'b1,1'b0,1'b1};
    tv[17] = '{1'b0,1'b1,8'h00,1'b1, 1'b0,1'b0,8'h02,1'b0,1'b0,1'b0};
    // L=1 packet with a stall and an empty FIFO mid-packet
    tv[18] = '{1'b0,1'b0,8'h04,1'b0, 1'b1,1'b0,8'h02,1'b0,1'b0,1'b0};
    tv[19] = '{1'b0,1'b0,8'h55,1'b0, 1'b0,1'b1,8'h04,1'b0,1'b0,1'b1};
    tv[20] = '{1'b0,1'b1,8'h00,1'b1, 1'b0,1'b1,8'h04,1'b0,1'b0,1'b1};
    tv[21] = '{1'b0,1'b1,8'h00,1'b1, 1'b0,1'b0,8'h04,1'b0,1'b0,1'b1};
    tv[22] = '{1'b0,1'b0,8'h55,1'b1, 1'b1,1'b0,8'h04,1'b0,1'b0,1'b1};
    tv[23] = '{1'b0,1'b0,8'h51,1'b1, 1'b1,1'b1,8'h55,1'b0,1'b0,1'b1};
    tv[24] = '{1'b0,1'b1,8'h00,1'b1, 1'b0,1'b1,8'h51,1'b1,1'b0,1'b1};
    tv[25] = '{1'b0,1'b1,8'h00,1'b1, 1'b0,1'b0,8'h51,1'b0,1'b0,1'b0};

    repeat (2) @(posedge clock);

    for (int i = 0; i < 26; i++) begin
      step(tv[i].rst, tv[i].emp,
           tv[i].din, tv[i].ren);
      chk($sformatf("v%0d rd_en", i),
          8'(fifo_rd_en), 8'(tv[i].e_rd));
      chk($sformatf("v%0d vld", i),
          8'(vld_out), 8'(tv[i].e_vld));
      chk($sformatf("v%0d dout", i),
          data_out, tv[i].e_dout);
      chk($sformatf("v%0d done", i),
          8'(pkt_done), 8'(tv[i].e_done));
      chk($sformatf("v%0d perr", i),
          8'(parity_err), 8'(tv[i].e_perr));
      chk($sformatf("v%0d busy", i),
          8'(busy), 8'(tv[i].e_busy));
      chk($sformatf("v%0d soft", i),
          8'(soft_reset), 8'h00);
    end

    // timeout: 30 stalled cycles with a valid byte
    step(1'b0, 1'b0, 8'h0D, 1'b0);
    chk("to load", 8'(fifo_rd_en), 8'h01);
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 1'b0, 8'h11, 1'b0);
      chk($sformatf("to soft c%0d", k),
          8'(soft_reset), 8'(k == 30));
      chk($sformatf("to rd_en c%0d", k),
          8'(fifo_rd_en), 8'h00);
      chk($sformatf("to vld c%0d", k),
          8'(vld_out), 8'h01);
    end
    chk("to done", 8'(pkt_done), 8'h00);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("to post vld", 8'(vld_out), 8'h00);
    chk("to post busy", 8'(busy), 8'h00);
    chk("to post soft", 8'(soft_reset), 8'h00);
    chk("to post done", 8'(pkt_done), 8'h00);
    step(1'b0, 1'b0, 8'h02, 1'b1);
    chk("to hdr rd", 8'(fifo_rd_en), 8'h01);
    step(1'b0, 1'b0, 8'h02, 1'b1);
    chk("to hdr dout", data_out, 8'h02);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("to pkt done", 8'(pkt_done), 8'h01);
    chk("to pkt perr", 8'(parity_err), 8'h00);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("to idle vld", 8'(vld_out), 8'h00);

    // stall for 29 cycles then recover with data intact
    step(1'b0, 1'b0, 8'h0D, 1'b0);
    chk("sr load", 8'(fifo_rd_en), 8'h01);
    for (int k = 1; k <= 29; k++) begin
      step(1'b0, 1'b0, 8'h11, 1'b0);
      chk($sformatf("sr soft c%0d", k),
          8'(soft_reset), 8'h00);
    end
    step(1'b0, 1'b0, 8'h11, 1'b1);
    chk("sr soft rel", 8'(soft_reset), 8'h00);
    chk("sr rd rel", 8'(fifo_rd_en), 8'h01);
    chk("sr dout hdr", data_out, 8'h0D);
    step(1'b0, 1'b0, 8'h22, 1'b1);
    chk("sr dout p1", data_out, 8'h11);
    step(1'b0, 1'b0, 8'h33, 1'b1);
    chk("sr dout p2", data_out, 8'h22);
    step(1'b0, 1'b0, 8'h0D, 1'b1);
    chk("sr dout p3", data_out, 8'h33);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("sr dout par", data_out, 8'h0D);
    chk("sr done", 8'(pkt_done), 8'h01);
    chk("sr perr", 8'(parity_err), 8'h00);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("sr idle busy", 8'(busy), 8'h00);

    // reset asserted mid-payload
    step(1'b0, 1'b0, 8'h0D, 1'b1);
    chk("rm load", 8'(fifo_rd_en), 8'h01);
    step(1'b0, 1'b0, 8'h11, 1'b1);
    chk("rm dout", data_out, 8'h0D);
    step(1'b1, 1'b0, 8'h22, 1'b1);
    chk("rm rst rd", 8'(fifo_rd_en), 8'h00);
    chk("rm rst done", 8'(pkt_done), 8'h00);
    chk("rm rst soft", 8'(soft_reset), 8'h00);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("rm post vld", 8'(vld_out), 8'h00);
    chk("rm post dout", data_out, 8'h00);
    chk("rm post busy", 8'(busy), 8'h00);
    step(1'b0, 1'b0, 8'h02, 1'b1);
    chk("rm hdr rd", 8'(fifo_rd_en), 8'h01);
    step(1'b0, 1'b0, 8'h02, 1'b1);
    chk("rm hdr vld", 8'(vld_out), 8'h01);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("rm done", 8'(pkt_done), 8'h01);
    chk("rm perr", 8'(parity_err), 8'h00);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("rm idle", 8'(busy), 8'h00);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
